codec_i2c_sequencer: RTL and testbench

Sequences all I2C register writes to the WM8731. After init_start it walks a fixed 11-entry configuration table and issues each 24-bit packet to the I2C master, with retry and timeout. After init completes, it arbitrates host-register commands onto the same I2C master. It sits between the Avalon slave register block (I2C_DATA_AUDIO / i2c_idle) and the I2C bit-level master.

---
 rtl/codec_pkg.sv | 36 +++
 rtl/codec_i2c_sequencer_if.sv | 27 ++
 rtl/codec_init_rom.sv | 29 ++
 rtl/codec_i2c_sequencer.sv | 155 +++++++++++++++
 tb/tb_codec_i2c_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared state encoding, table sizing and WM8731 register map
package codec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE,
    CHECK,
    READY,
    ERROR
  } state_t;

  localparam int         TABLE_DEPTH = 11;
  localparam logic [3:0] LAST_IDX    = 4'(TABLE_DEPTH - 1);
  localparam logic [3:0] HOST_IDX    = 4'hF;

  localparam logic [6:0] REG_LLINE  = 7'h00;
  localparam logic [6:0] REG_RLINE  = 7'h01;
  localparam logic [6:0] REG_LHP    = 7'h02;
  localparam logic [6:0] REG_RHP    = 7'h03;
  localparam logic [6:0] REG_APATH  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWR    = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  function automatic logic [23:0] mk_packet(input logic [7:0] dev, input logic [6:0] addr,
                                            input logic [8:0] data);
    return {dev, addr, data};
  endfunction

endpackage

// File: rtl/codec_i2c_sequencer_if.sv
// rtl/codec_i2c_sequencer_if.sv - host, init-control and I2C master signals of the sequencer
interface codec_i2c_sequencer_if;

  logic        init_start;
  logic        host_req;
  logic [23:0] host_packet;
  logic        host_ack;
  logic        i2c_idle;
  logic        i2c_nack;
  logic        i2c_start;
  logic [23:0] i2c_packet;
  logic        init_done;
  logic        busy;
  logic        err;
  logic [3:0]  err_index;

  modport master (
    input  init_start, host_req, host_packet, i2c_idle, i2c_nack,
    output host_ack, i2c_start, i2c_packet, init_done, busy, err, err_index
  );

  modport slave (
    output init_start, host_req, host_packet, i2c_idle, i2c_nack,
    input  host_ack, i2c_start, i2c_packet, init_done, busy, err, err_index
  );

endinterface

// File: rtl/codec_init_rom.sv
// rtl/codec_init_rom.sv - WM8731 power-up configuration table, index to 24-bit I2C packet
module codec_init_rom
  import codec_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = 8'h34
) (
  input  logic [3:0]  idx_i,
  output logic [23:0] packet_o
);

  always_comb begin
    packet_o = '0;
    case (idx_i)
      4'd0:    packet_o = mk_packet(DEV_ADDR, REG_RESET,  9'h000);
      4'd1:    packet_o = mk_packet(DEV_ADDR, REG_PWR,    9'h000);
      4'd2:    packet_o = mk_packet(DEV_ADDR, REG_APATH,  9'h012);
      4'd3:    packet_o = mk_packet(DEV_ADDR, REG_DPATH,  9'h000);
      4'd4:    packet_o = mk_packet(DEV_ADDR, REG_IFACE,  9'h002);
      4'd5:    packet_o = mk_packet(DEV_ADDR, REG_SRATE,  9'h000);
      4'd6:    packet_o = mk_packet(DEV_ADDR, REG_LLINE,  9'h017);
      4'd7:    packet_o = mk_packet(DEV_ADDR, REG_RLINE,  9'h017);
      4'd8:    packet_o = mk_packet(DEV_ADDR, REG_LHP,    9'h079);
      4'd9:    packet_o = mk_packet(DEV_ADDR, REG_RHP,    9'h079);
      4'd10:   packet_o = mk_packet(DEV_ADDR, REG_ACTIVE, 9'h001);
      default: packet_o = '0;
    endcase
  end

endmodule

// File: rtl/codec_i2c_sequencer.sv
// rtl/codec_i2c_sequencer.sv - walks the codec init table, then arbitrates host packets
// onto the I2C master with per-phase timeout and bounded retry.
module codec_i2c_sequencer
  import codec_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int          MAX_RETRY      = 2,
  parameter logic [7:0]  DEV_ADDR       = 8'h34
) (
  input logic Clk,
  input logic Rst,
  codec_i2c_sequencer_if.master bus
);

  localparam logic [15:0] TIMER_LAST  = TIMEOUT_CYCLES - 16'd1;
  localparam logic [1:0]  RETRY_LIMIT = 2'(MAX_RETRY);

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [1:0]  retry_q;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic        host_mode_q;
  logic        fail_q;
  logic [23:0] host_pkt_q;
  logic [23:0] packet_q;
  logic        i2c_start_q;
  logic        host_ack_q;
  logic        init_done_q;
  logic        busy_q;
  logic        err_q;
  logic [3:0]  err_index_q;
  logic [23:0] rom_packet;
  logic        timer_expired;
  logic        init_grant;

  codec_init_rom #(.DEV_ADDR(DEV_ADDR)) u_rom (
    .idx_i    (idx_q),
    .packet_o (rom_packet)
  );

  assign timer_expired = (timer_q == TIMER_LAST);
  assign timer_d       = timer_expired ? timer_q : timer_q + 16'd1;
  // A table (re)run may only start from a resting state; it beats a pending host request.
  assign init_grant    = bus.init_start && (state_q inside {IDLE, READY, ERROR});

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      host_mode_q <= 1'b0;
      fail_q      <= 1'b0;
      host_pkt_q  <= '0;
      packet_q    <= '0;
      i2c_start_q <= 1'b0;
      host_ack_q  <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
    end else begin
      i2c_start_q <= 1'b0;
      host_ack_q  <= 1'b0;
      if (init_grant) begin
        state_q     <= LOAD;
        host_mode_q <= 1'b0;
        idx_q       <= '0;
        init_done_q <= 1'b0;
        err_q       <= 1'b0;
        err_index_q <= '0;
      end else begin
        case (state_q)
          LOAD: begin
            packet_q <= host_mode_q ? host_pkt_q : rom_packet;
            retry_q  <= '0;
            state_q  <= ISSUE;
          end
          ISSUE: begin
            i2c_start_q <= 1'b1;
            busy_q      <= 1'b1;
            timer_q     <= '0;
            fail_q      <= 1'b0;
            state_q     <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (!bus.i2c_idle) begin
              timer_q <= '0;
              state_q <= WAIT_IDLE;
            end else if (timer_expired) begin
              fail_q  <= 1'b1;
              state_q <= CHECK;
            end else begin
              timer_q <= timer_d;
            end
          end
          WAIT_IDLE: begin
            if (bus.i2c_idle) begin
              fail_q  <= bus.i2c_nack;
              state_q <= CHECK;
            end else if (timer_expired) begin
              fail_q  <= 1'b1;
              state_q <= CHECK;
            end else begin
              timer_q <= timer_d;
            end
          end
          CHECK: begin
            if (!fail_q) begin
              if (host_mode_q) begin
                busy_q  <= 1'b0;
                state_q <= READY;
              end else if (idx_q == LAST_IDX) begin
                init_done_q <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= READY;
              end else begin
                idx_q   <= idx_q + 4'd1;
                state_q <= LOAD;
              end
            end else if (retry_q < RETRY_LIMIT) begin
              retry_q <= retry_q + 2'd1;
              state_q <= ISSUE;
            end else begin
              // A failed host write leaves the configured codec usable, so init_done stays.
              err_q       <= 1'b1;
              busy_q      <= 1'b0;
              err_index_q <= host_mode_q ? HOST_IDX : idx_q;
              state_q     <= host_mode_q ? READY : ERROR;
            end
          end
          READY: begin
            if (bus.host_req) begin
              host_pkt_q  <= bus.host_packet;
              host_ack_q  <= 1'b1;
              host_mode_q <= 1'b1;
              state_q     <= LOAD;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign bus.i2c_start  = i2c_start_q;
  assign bus.i2c_packet = packet_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.init_done  = init_done_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.err_index  = err_index_q;

endmodule

// File: tb/tb_codec_i2c_sequencer.sv
// tb/tb_codec_i2c_sequencer.sv - directed self-checking bench with a behavioural I2C master model
module tb_codec_i2c_sequencer;
  import codec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  codec_i2c_sequencer_if bus();

  codec_i2c_sequencer #(
    .TIMEOUT_CYCLES (16'd100),
    .MAX_RETRY      (2),
    .DEV_ADDR       (8'h34)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_tab [0:10] = '{24'h341E00, 24'h340C00, 24'h340812, 24'h340A00, 24'h340E02,
                                  24'h341000, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                                  24'h341201};
  logic [23:0] pkt_log   [0:63];
  int          start_cyc [0:63];
  int          n_start   = 0;
  int          ack_count = 0;
  int          cyc       = 0;

  bit          model_up        = 1'b0;
  bit          m_active        = 1'b0;
  int          m_cnt           = 0;
  bit          cur_nack        = 1'b0;
  bit          never_drop      = 1'b0;
  bit          nack_once_en    = 1'b0;
  bit          nack_always_en  = 1'b0;
  logic [23:0] nack_once_pkt   = '0;
  logic [23:0] nack_always_pkt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // I2C master model: idle drops 3 cycles after start and returns 20 cycles later.
  always @(negedge clk) begin
    if (!model_up) begin
      bus.i2c_idle = 1'b1;
      bus.i2c_nack = 1'b0;
      model_up     = 1'b1;
    end
    if (bus.host_ack === 1'b1) ack_count++;
    if (bus.i2c_start === 1'b1) begin
      if (n_start < 64) begin
        pkt_log[n_start]   = bus.i2c_packet;
        start_cyc[n_start] = cyc;
      end
      n_start++;
      cur_nack = (nack_always_en && bus.i2c_packet == nack_always_pkt) ||
                 (nack_once_en && bus.i2c_packet == nack_once_pkt);
      if (nack_once_en && bus.i2c_packet == nack_once_pkt) nack_once_en = 1'b0;
      m_active = !never_drop;
      m_cnt    = 0;
    end else if (m_active) begin
      m_cnt++;
      if (m_cnt == 3) bus.i2c_idle = 1'b0;
      if (m_cnt == 23) begin
        bus.i2c_idle = 1'b1;
        bus.i2c_nack = cur_nack;
        m_active     = 1'b0;
      end
    end
  end

  task automatic clear_log();
    n_start   = 0;
    ack_count = 0;
    for (int i = 0; i < 64; i++) pkt_log[i] = '0;
  endtask

  task automatic pulse_init();
    @(negedge clk);
    bus.init_start = 1'b1;
    @(negedge clk);
    bus.init_start = 1'b0;
  endtask

  task automatic wait_end(input int max, output bit timed_out);
    int n = 0;
    while (!(bus.init_done === 1'b1 || bus.err === 1'b1) && n < max) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= max);
  endtask

  task automatic wait_ack_and_drop(input int max, output bit timed_out);
    int n = 0;
    while (bus.host_ack !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= max);
    bus.host_req = 1'b0;
    repeat (5) @(negedge clk);
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({bus.i2c_start, bus.host_ack, bus.init_done, bus.busy, bus.err, bus.err_index} !== 9'h000) begin errors++; $display("FAIL reset_flags got %h want 000", {bus.i2c_start, bus.host_ack, bus.init_done, bus.busy, bus.err, bus.err_index}); end
    checks++; if (bus.i2c_packet !== 24'h000000) begin errors++; $display("FAIL reset_packet got %h want 000000", bus.i2c_packet); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, IDLE); end
    rst = 1'b0;
    bus.host_req    = 1'b1;
    bus.host_packet = 24'h341E00;
    ack_count       = 0;
    repeat (6) @(negedge clk);
    bus.host_req = 1'b0;
    checks++; if (ack_count !== 0 || dut.state_q !== IDLE) begin errors++; $display("FAIL idle_host_ignored got acks %0d state %0d want 0 %0d", ack_count, dut.state_q, IDLE); end
  endtask

  task automatic test_init_happy();
    bit to;
    clear_log();
    pulse_init();
    wait_end(2000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL happy_timeout got %0d want 0", to); end
    checks++; if (n_start !== 11) begin errors++; $display("FAIL happy_starts got %0d want 11", n_start); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (pkt_log[i] !== exp_tab[i]) begin errors++; $display("FAIL happy_pkt%0d got %h want %h", i, pkt_log[i], exp_tab[i]); end
    end
    checks++; if ({bus.init_done, bus.err, bus.busy} !== 3'b100) begin errors++; $display("FAIL happy_status got %b want 100", {bus.init_done, bus.err, bus.busy}); end
    checks++; if (dut.state_q !== READY) begin errors++; $display("FAIL happy_state got %0d want %0d", dut.state_q, READY); end
  endtask

  task automatic test_rst_midflight();
    int n = 0;
    clear_log();
    pulse_init();
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (dut.state_q !== IDLE || {bus.init_done, bus.busy, bus.i2c_start} !== 3'b000) begin errors++; $display("FAIL rst_mid got state %0d flags %b want %0d 000", dut.state_q, {bus.init_done, bus.busy, bus.i2c_start}, IDLE); end
    while (m_active && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_nack_retry();
    bit to;
    nack_once_pkt = 24'h340E02;
    nack_once_en  = 1'b1;
    clear_log();
    pulse_init();
    wait_end(2000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL retry_timeout got %0d want 0", to); end
    checks++; if (n_start !== 12) begin errors++; $display("FAIL retry_starts got %0d want 12", n_start); end
    checks++; if ({pkt_log[4], pkt_log[5]} !== {24'h340E02, 24'h340E02}) begin errors++; $display("FAIL retry_repeat got %h %h want 340e02 340e02", pkt_log[4], pkt_log[5]); end
    checks++; if ({pkt_log[6], pkt_log[11]} !== {24'h341000, 24'h341201}) begin errors++; $display("FAIL retry_tail got %h %h want 341000 341201", pkt_log[6], pkt_log[11]); end
    checks++; if ({bus.init_done, bus.err} !== 2'b10) begin errors++; $display("FAIL retry_status got %b want 10", {bus.init_done, bus.err}); end
  endtask

  task automatic test_persistent_nack();
    bit to;
    nack_always_pkt = 24'h340812;
    nack_always_en  = 1'b1;
    clear_log();
    pulse_init();
    wait_end(2000, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL pnack_timeout got %0d want 0", to); end
    checks++; if ({bus.err, bus.err_index, bus.init_done, bus.busy} !== 7'b1_0010_00) begin errors++; $display("FAIL pnack_status got err %b idx %h done %b busy %b want 1 2 0 0", bus.err, bus.err_index, bus.init_done, bus.busy); end
    checks++; if (dut.state_q !== ERROR) begin errors++; $display("FAIL pnack_state got %0d want %0d", dut.state_q, ERROR); end
    checks++; if (n_start !== 5) begin errors++; $display("FAIL pnack_starts got %0d want 5", n_start); end
    for (int i = 2; i < 5; i++) begin
      checks++; if (pkt_log[i] !== 24'h340812) begin errors++; $display("FAIL pnack_pkt%0d got %h want 340812", i, pkt_log[i]); end
    end
    bus.host_req    = 1'b1;
    bus.host_packet = 24'h340A00;
    ack_count       = 0;
    repeat (40) @(negedge clk);
    bus.host_req = 1'b0;
    checks++; if (ack_count !== 0 || dut.state_q !== ERROR) begin errors++; $display("FAIL error_host_ignored got acks %0d state %0d want 0 %0d", ack_count, dut.state_q, ERROR); end
    nack_always_en = 1'b0;
    clear_log();
    pulse_init();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL restart_err_clear got %b want 0", bus.err); end
    wait_end(2000, to);
    checks++; if ({to, bus.init_done, n_start[7:0], pkt_log[0]} !== {1'b0, 1'b1, 8'd11, 24'h341E00}) begin errors++; $display("FAIL restart_run got to %b done %b starts %0d first %h want 0 1 11 341e00", to, bus.init_done, n_start, pkt_log[0]); end
  endtask

  task automatic test_timeout();
    bit to;
    int gap;
    never_drop = 1'b1;
    clear_log();
    pulse_init();
    wait_end(1000, to);
    checks++; if ({to, bus.err, bus.err_index} !== {1'b0, 1'b1, 4'h0}) begin errors++; $display("FAIL tmo_status got to %b err %b idx %h want 0 1 0", to, bus.err, bus.err_index); end
    checks++; if (n_start !== 3) begin errors++; $display("FAIL tmo_starts got %0d want 3", n_start); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (pkt_log[i] !== 24'h341E00) begin errors++; $display("FAIL tmo_pkt%0d got %h want 341e00", i, pkt_log[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      gap = start_cyc[i] - start_cyc[i-1];
      checks++; if (gap < 99 || gap > 105) begin errors++; $display("FAIL tmo_gap%0d got %0d want 99..105", i, gap); end
    end
    checks++; if (dut.state_q !== ERROR) begin errors++; $display("FAIL tmo_state got %0d want %0d", dut.state_q, ERROR); end
    never_drop = 1'b0;
  endtask

  task automatic test_host_arb();
    bit to;
    bit ack_to;
    int early_acks;
    bus.host_packet = 24'h341E00;
    clear_log();
    pulse_init();
    repeat (2) @(negedge clk);
    bus.host_req = 1'b1;
    wait_end(2000, to);
    early_acks = ack_count;
    checks++; if ({to, bus.init_done, bus.err} !== 3'b010) begin errors++; $display("FAIL host_init got to %b done %b err %b want 0 1 0", to, bus.init_done, bus.err); end
    checks++; if (early_acks !== 0) begin errors++; $display("FAIL host_early_ack got %0d want 0", early_acks); end
    wait_ack_and_drop(20, ack_to);
    checks++; if ({ack_to, ack_count[7:0]} !== {1'b0, 8'd1}) begin errors++; $display("FAIL host_ack got to %b acks %0d want 0 1", ack_to, ack_count); end
    checks++; if ({n_start[7:0], pkt_log[11]} !== {8'd12, 24'h341E00}) begin errors++; $display("FAIL host_issue got starts %0d pkt %h want 12 341e00", n_start, pkt_log[11]); end
    checks++; if (dut.state_q !== READY || {bus.init_done, bus.err, bus.busy} !== 3'b100) begin errors++; $display("FAIL host_ready got state %0d flags %b want %0d 100", dut.state_q, {bus.init_done, bus.err, bus.busy}, READY); end
  endtask

  task automatic test_simultaneous();
    bit to;
    bit ack_to;
    int early_acks;
    clear_log();
    @(negedge clk);
    bus.init_start  = 1'b1;
    bus.host_req    = 1'b1;
    bus.host_packet = 24'h340A00;
    @(negedge clk);
    bus.init_start = 1'b0;
    checks++; if (bus.host_ack !== 1'b0 || dut.state_q !== LOAD || bus.init_done !== 1'b0) begin errors++; $display("FAIL simul_grant got ack %b state %0d done %b want 0 %0d 0", bus.host_ack, dut.state_q, bus.init_done, LOAD); end
    wait_end(2000, to);
    early_acks = ack_count;
    checks++; if ({to, bus.init_done, early_acks[7:0]} !== {1'b0, 1'b1, 8'd0}) begin errors++; $display("FAIL simul_init got to %b done %b acks %0d want 0 1 0", to, bus.init_done, early_acks); end
    wait_ack_and_drop(20, ack_to);
    checks++; if ({ack_to, ack_count[7:0], n_start[7:0]} !== {1'b0, 8'd1, 8'd12}) begin errors++; $display("FAIL simul_host got to %b acks %0d starts %0d want 0 1 12", ack_to, ack_count, n_start); end
    checks++; if ({pkt_log[0], pkt_log[11]} !== {24'h341E00, 24'h340A00}) begin errors++; $display("FAIL simul_order got %h %h want 341e00 340a00", pkt_log[0], pkt_log[11]); end
  endtask

  initial begin
    rst             = 1'b1;
    bus.init_start  = 1'b0;
    bus.host_req    = 1'b0;
    bus.host_packet = '0;
    test_reset();
    test_init_happy();
    test_rst_midflight();
    test_nack_retry();
    test_persistent_nack();
    test_timeout();
    test_host_arb();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
